btn_conditioner: RTL

- Upstream stage of the manual traffic-light controller FSM: turns the raw, bouncing, asynchronous direction switch/button into the clean `button_i` level the FSM consumes.
- Synchronises the input, debounces it with a qualifying counter driven by an explicit state machine, and emits one-cycle press/release pulses.
- Optionally converts momentary presses into a toggled direction level.

---
 rtl/btn_conditioner_if.sv | 44 ++++
 rtl/btn_conditioner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner_if.sv
// ============================================================================
// Module      : btn_conditioner_if
// Description : Signal bundle between the button conditioner and its user.
//               The master side drives the raw button and the count-enable
//               strobe and receives the conditioned outputs. The slave side
//               is the conditioner itself.
// Signals     : tick_i      - debounce count enable (prescaler strobe)
//               btn_raw_i   - raw asynchronous switch/button, active high
//               button_o    - conditioned direction level for the FSM
//               btn_level_o - plain debounced level
//               press_o     - one-cycle pulse per accepted press
//               release_o   - one-cycle pulse per accepted release
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btn_conditioner_if;
   logic tick_i;
   logic btn_raw_i;
   logic button_o;
   logic btn_level_o;
   logic press_o;
   logic release_o;

   modport master (
      output tick_i,
      output btn_raw_i,
      input  button_o,
      input  btn_level_o,
      input  press_o,
      input  release_o
   );

   modport slave (
      input  tick_i,
      input  btn_raw_i,
      output button_o,
      output btn_level_o,
      output press_o,
      output release_o
   );
endinterface

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module      : btn_conditioner
// Description : Synchronises, debounces and edge-detects a raw direction
//               button for the manual traffic-light controller FSM.
//               A two-flop synchroniser feeds a four-state qualifying state
//               machine. A new level is accepted only once it has held for
//               DEBOUNCE_CYCLES ticks. Press and release pulses last one
//               cycle each.
// Ports       : clk_f - system clock
//               rst_i - asynchronous active-low reset
//               bus   - btn_conditioner_if.slave (tick_i, btn_raw_i,
//                       button_o, btn_level_o, press_o, release_o)
// Parameters  : DEBOUNCE_CYCLES - qualifying ticks, legal range 2..65535
// Options     : BTN_TOGGLE_EN - when defined, button_o is a toggle register
//               that flips on every accepted press. When undefined,
//               button_o follows btn_level_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  wire               clk_f,
   input  wire               rst_i,
   btn_conditioner_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARM_P = 2'd1;
   localparam logic [1:0] S_HIGH  = 2'd2;
   localparam logic [1:0] S_ARM_R = 2'd3;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   // ------------------------------------------------------------------------
   // State register, synchroniser and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_f or negedge rst_i) begin
      if (!rst_i) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // The synchroniser runs every clock; tick_i only paces the counter.
   always_comb begin
      sync1_d = bus.btn_raw_i;
      sync2_d = sync1_q;
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (sync2_q) begin
               state_d = S_ARM_P;
               cnt_d   = '0;
            end
         end
         S_ARM_P: begin
            // Any reversion restarts qualification from scratch.
            if (!sync2_q) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (bus.tick_i) begin
               if (cnt_q == CNT_MAX) begin
                  state_d = S_HIGH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_HIGH: begin
            if (!sync2_q) begin
               state_d = S_ARM_R;
               cnt_d   = '0;
            end
         end
         S_ARM_R: begin
            if (sync2_q) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (bus.tick_i) begin
               if (cnt_q == CNT_MAX) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic
   // The outputs are decoded from the upcoming state, so each registered
   // output changes on the same edge as the state register.
   // ------------------------------------------------------------------------
   always_comb begin
      level_d   = (state_d == S_HIGH) || (state_d == S_ARM_R);
      press_d   = (state_q == S_ARM_P) && (state_d == S_HIGH);
      release_d = (state_q == S_ARM_R) && (state_d == S_IDLE);
   end

   assign bus.btn_level_o = level_q;
   assign bus.press_o     = press_q;
   assign bus.release_o   = release_q;

`ifdef BTN_TOGGLE_EN
   logic toggle_q, toggle_d;

   // The toggle register flips on the same edge that raises press_o.
   // This keeps button_o aligned with btn_level_o on the first press.
   always_comb begin
      toggle_d = toggle_q ^ press_d;
   end

   always_ff @(posedge clk_f or negedge rst_i) begin
      if (!rst_i) begin
         toggle_q <= 1'b0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   assign bus.button_o = toggle_q;
`else
   assign bus.button_o = level_q;
`endif

endmodule

`default_nettype wire
